// File: rtl/load_store_unit.sv
// load_store_unit
// Memory-access stage: takes one decoded load/store request, runs a single
// word-aligned req/ack transaction on the data-memory bus and returns the
// sign/zero-extended load result with a one-cycle completion pulse.
// Misaligned, illegal-funct3 and timed-out accesses complete as faults.
//
// Ports
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   req_valid_i/req_ready_o decoded access present / unit idle
//   mem_write_enable_i      store, mem_read_enable_i load
//   funct3_i, addr_i        access size/sign, byte address
//   store_data_i            rs2 value
//   resp_valid_o            completion pulse with load_data_o/fault_o/fault_cause_o
//   stall_o                 hold fetch/decode (combinational)
//   dmem_*                  data-memory bus (req/we/addr/be/wdata out, rdata/ack in)
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        mem_write_enable_i,
  input  logic        mem_read_enable_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic        resp_valid_o,
  output logic [31:0] load_data_o,
  output logic        fault_o,
  output logic [1:0]  fault_cause_o,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [7:0] TIMEOUT_C = TIMEOUT_CYCLES[7:0];

  logic [1:0]  state_r;
  logic [7:0]  cnt_r;
  logic [1:0]  off_r;
  logic [2:0]  f3_r;
  logic        req_r;
  logic        we_r;
  logic [31:0] addr_r;
  logic [3:0]  be_r;
  logic [31:0] wdata_r;
  logic        resp_valid_r;
  logic        fault_r;
  logic [1:0]  cause_r;
  logic [31:0] load_data_r;

  logic        accept_s;
  logic        illegal_s;
  logic        misaligned_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;

  // Pick the addressed byte/half out of the bus word and extend it per funct3.
  function automatic logic [31:0] extract_load(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      2'd3:    b = rdata[31:24];
      default: b = 8'h00;
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  extract_load = {{24{b[7]}}, b};
      3'b001:  extract_load = {{16{h[15]}}, h};
      3'b010:  extract_load = rdata;
      3'b100:  extract_load = {24'h000000, b};
      3'b101:  extract_load = {16'h0000, h};
      default: extract_load = 32'h0000_0000;
    endcase
  endfunction

  // Request decode: accept, fault classification and store lane steering.
  always_comb begin
    accept_s = (state_r == ST_IDLE) && req_valid_i &&
               (mem_write_enable_i || mem_read_enable_i);

    // Unsigned loads have no store counterpart; write enable wins when both set.
    case (funct3_i)
      3'b000, 3'b001, 3'b010: illegal_s = 1'b0;
      3'b100, 3'b101:         illegal_s = mem_write_enable_i;
      default:                illegal_s = 1'b1;
    endcase

    case (funct3_i[1:0])
      2'b00: begin
        misaligned_s = 1'b0;
        be_s         = 4'b0001 << addr_i[1:0];
        wdata_s      = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        misaligned_s = addr_i[0];
        be_s         = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_s      = {2{store_data_i[15:0]}};
      end
      2'b10: begin
        misaligned_s = (addr_i[1:0] != 2'b00);
        be_s         = 4'b1111;
        wdata_s      = store_data_i;
      end
      default: begin
        misaligned_s = 1'b0;
        be_s         = 4'b0000;
        wdata_s      = 32'h0000_0000;
      end
    endcase

    if (!mem_write_enable_i) begin
      wdata_s = 32'h0000_0000;
    end else begin
      wdata_s = wdata_s;
    end
  end

  // Transaction FSM and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 8'd0;
      off_r        <= 2'd0;
      f3_r         <= 3'd0;
      req_r        <= 1'b0;
      we_r         <= 1'b0;
      addr_r       <= 32'h0000_0000;
      be_r         <= 4'h0;
      wdata_r      <= 32'h0000_0000;
      resp_valid_r <= 1'b0;
      fault_r      <= 1'b0;
      cause_r      <= 2'b00;
      load_data_r  <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          resp_valid_r <= 1'b0;
          if (accept_s) begin
            if (illegal_s || misaligned_s) begin
              // Faulting access completes without touching the bus.
              state_r      <= ST_RESP;
              resp_valid_r <= 1'b1;
              fault_r      <= 1'b1;
              cause_r      <= illegal_s ? 2'b10 : 2'b01;
              load_data_r  <= 32'h0000_0000;
            end else begin
              state_r <= ST_REQ;
              req_r   <= 1'b1;
              we_r    <= mem_write_enable_i;
              addr_r  <= {addr_i[31:2], 2'b00};
              be_r    <= be_s;
              wdata_r <= wdata_s;
              cnt_r   <= 8'd0;
              off_r   <= addr_i[1:0];
              f3_r    <= funct3_i;
            end
          end
        end
        ST_REQ: begin
          if (dmem_ack_i) begin
            state_r      <= ST_RESP;
            req_r        <= 1'b0;
            resp_valid_r <= 1'b1;
            fault_r      <= 1'b0;
            cause_r      <= 2'b00;
            load_data_r  <= we_r ? 32'h0000_0000 : extract_load(f3_r, off_r, dmem_rdata_i);
          end else if ((cnt_r + 8'd1) == TIMEOUT_C) begin
            state_r      <= ST_RESP;
            req_r        <= 1'b0;
            resp_valid_r <= 1'b1;
            fault_r      <= 1'b1;
            cause_r      <= 2'b11;
            load_data_r  <= 32'h0000_0000;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        ST_RESP: begin
          state_r      <= ST_IDLE;
          resp_valid_r <= 1'b0;
        end
        default: begin
          state_r      <= ST_IDLE;
          req_r        <= 1'b0;
          resp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o   = (state_r == ST_IDLE);
  // The core must hold in the accept cycle and for every bus wait cycle.
  assign stall_o       = accept_s || (state_r == ST_REQ);
  assign resp_valid_o  = resp_valid_r;
  assign load_data_o   = load_data_r;
  assign fault_o       = fault_r;
  assign fault_cause_o = cause_r;
  assign dmem_req_o    = req_r;
  assign dmem_we_o     = we_r;
  assign dmem_addr_o   = addr_r;
  assign dmem_be_o     = be_r;
  assign dmem_wdata_o  = wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        mem_we;
  logic        mem_re;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  // Outputs of the default-timeout instance (a) and TIMEOUT_CYCLES=4 instance (b)
  logic        ready_a, resp_a, fault_a, stall_a, req_a, we_a;
  logic [31:0] ld_a, daddr_a, wdata_a;
  logic [1:0]  cause_a;
  logic [3:0]  be_a;
  logic        ready_b, resp_b, fault_b, stall_b, req_b, we_b;
  logic [31:0] ld_b, daddr_b, wdata_b;
  logic [1:0]  cause_b;
  logic [3:0]  be_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(ready_a),
    .mem_write_enable_i(mem_we), .mem_read_enable_i(mem_re), .funct3_i(funct3),
    .addr_i(addr), .store_data_i(store_data), .resp_valid_o(resp_a),
    .load_data_o(ld_a), .fault_o(fault_a), .fault_cause_o(cause_a), .stall_o(stall_a),
    .dmem_req_o(req_a), .dmem_we_o(we_a), .dmem_addr_o(daddr_a), .dmem_be_o(be_a),
    .dmem_wdata_o(wdata_a), .dmem_rdata_i(dmem_rdata), .dmem_ack_i(dmem_ack)
  );

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(ready_b),
    .mem_write_enable_i(mem_we), .mem_read_enable_i(mem_re), .funct3_i(funct3),
    .addr_i(addr), .store_data_i(store_data), .resp_valid_o(resp_b),
    .load_data_o(ld_b), .fault_o(fault_b), .fault_cause_o(cause_b), .stall_o(stall_b),
    .dmem_req_o(req_b), .dmem_we_o(we_b), .dmem_addr_o(daddr_b), .dmem_be_o(be_b),
    .dmem_wdata_o(wdata_b), .dmem_rdata_i(dmem_rdata), .dmem_ack_i(dmem_ack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request in the current (low) clock phase.
  task automatic issue(input logic we, input logic re, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    req_valid  = 1'b1;
    mem_we     = we;
    mem_re     = re;
    funct3     = f3;
    addr       = a;
    store_data = d;
    #1;
  endtask

  // Advance one clock; request and ack are single-cycle pulses.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    dmem_ack  = 1'b0;
    #1;
  endtask

  int stall_cnt;
  int resp_seen;
  int req_cnt;
  int resp_at;
  logic [1:0] cause_cap;
  logic       fault_cap;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; mem_we = 1'b0; mem_re = 1'b0;
    funct3 = 3'd0; addr = 32'd0; store_data = 32'd0;
    dmem_rdata = 32'd0; dmem_ack = 1'b0;
    #2;
    check("rst_req",   {31'd0, req_a},   32'd0);
    check("rst_we",    {31'd0, we_a},    32'd0);
    check("rst_resp",  {31'd0, resp_a},  32'd0);
    check("rst_fault", {31'd0, fault_a}, 32'd0);
    check("rst_stall", {31'd0, stall_a}, 32'd0);
    check("rst_ready", {31'd0, ready_a}, 32'd1);
    check("rst_addr",  daddr_a,          32'd0);
    check("rst_be",    {28'd0, be_a},    32'd0);
    check("rst_wdata", wdata_a,          32'd0);
    check("rst_ld",    ld_a,             32'd0);
    check("rst_cause", {30'd0, cause_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // SW 0x1004, ack on first REQ cycle
    issue(1'b1, 1'b0, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF);
    check("sw_stall_acc", {31'd0, stall_a}, 32'd1);
    cycle();
    check("sw_req",   {31'd0, req_a},  32'd1);
    check("sw_we",    {31'd0, we_a},   32'd1);
    check("sw_addr",  daddr_a,         32'h0000_1004);
    check("sw_be",    {28'd0, be_a},   32'hF);
    check("sw_wdata", wdata_a,         32'hDEAD_BEEF);
    check("sw_resp_early", {31'd0, resp_a}, 32'd0);
    dmem_ack = 1'b1;
    cycle();
    check("sw_resp",  {31'd0, resp_a},  32'd1);
    check("sw_fault", {31'd0, fault_a}, 32'd0);
    check("sw_ld",    ld_a,             32'd0);
    check("sw_req_drop", {31'd0, req_a}, 32'd0);
    check("sw_stall_resp", {31'd0, stall_a}, 32'd0);
    cycle();
    check("sw_resp_pulse", {31'd0, resp_a}, 32'd0);
    check("sw_ready", {31'd0, ready_a}, 32'd1);

    // LB 0x1003
    issue(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'd0);
    cycle();
    check("lb_be",    {28'd0, be_a}, 32'h8);
    check("lb_we",    {31'd0, we_a}, 32'd0);
    check("lb_wdata", wdata_a,       32'd0);
    check("lb_addr",  daddr_a,       32'h0000_1000);
    dmem_rdata = 32'h8012_3456; dmem_ack = 1'b1;
    cycle();
    check("lb_resp", {31'd0, resp_a}, 32'd1);
    check("lb_data", ld_a, 32'hFFFF_FF80);
    cycle();

    // LBU 0x1003
    issue(1'b0, 1'b1, 3'b100, 32'h0000_1003, 32'd0);
    cycle();
    dmem_ack = 1'b1;
    cycle();
    check("lbu_data", ld_a, 32'h0000_0080);
    cycle();

    // LHU 0x1002
    issue(1'b0, 1'b1, 3'b101, 32'h0000_1002, 32'd0);
    cycle();
    check("lhu_be", {28'd0, be_a}, 32'hC);
    dmem_rdata = 32'hBEEF_1234; dmem_ack = 1'b1;
    cycle();
    check("lhu_data", ld_a, 32'h0000_BEEF);
    cycle();

    // SB 0x1001, lane replication
    issue(1'b1, 1'b0, 3'b000, 32'h0000_1001, 32'h0000_00A5);
    cycle();
    check("sb_be",    {28'd0, be_a}, 32'h2);
    check("sb_wdata", wdata_a,       32'hA5A5_A5A5);
    dmem_ack = 1'b1;
    cycle();
    cycle();

    // SH 0x2002, ack delayed to the fifth REQ cycle
    stall_cnt = 0; resp_seen = 0;
    issue(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0000_ABCD);
    if (stall_a) stall_cnt++;
    cycle();
    check("sh_be",    {28'd0, be_a}, 32'hC);
    check("sh_wdata", wdata_a,       32'hABCD_ABCD);
    for (int i = 1; i <= 5; i++) begin
      if (stall_a) stall_cnt++;
      if (resp_a) resp_seen++;
      if (i == 5) dmem_ack = 1'b1;
      cycle();
    end
    check("sh_stall_cycles", stall_cnt, 32'd6);
    check("sh_no_early_resp", resp_seen, 32'd0);
    check("sh_resp", {31'd0, resp_a}, 32'd1);
    check("sh_stall_resp", {31'd0, stall_a}, 32'd0);
    cycle();

    // LW 0x3001: misaligned fault at accept
    issue(1'b0, 1'b1, 3'b010, 32'h0000_3001, 32'd0);
    check("mis_stall_acc", {31'd0, stall_a}, 32'd1);
    cycle();
    check("mis_req",   {31'd0, req_a},   32'd0);
    check("mis_resp",  {31'd0, resp_a},  32'd1);
    check("mis_fault", {31'd0, fault_a}, 32'd1);
    check("mis_cause", {30'd0, cause_a}, 32'd1);
    cycle();

    // Load funct3=011: illegal
    issue(1'b0, 1'b1, 3'b011, 32'h0000_3000, 32'd0);
    cycle();
    check("ill_req",   {31'd0, req_a},   32'd0);
    check("ill_resp",  {31'd0, resp_a},  32'd1);
    check("ill_fault", {31'd0, fault_a}, 32'd1);
    check("ill_cause", {30'd0, cause_a}, 32'd2);
    cycle();

    // Neither enable: ignored
    req_valid = 1'b1; #1;
    check("none_stall", {31'd0, stall_a}, 32'd0);
    cycle();
    check("none_req",   {31'd0, req_a},   32'd0);
    check("none_ready", {31'd0, ready_a}, 32'd1);

    // Stray ack in IDLE
    dmem_ack = 1'b1;
    cycle();
    check("stray_resp",  {31'd0, resp_a},  32'd0);
    check("stray_ready", {31'd0, ready_a}, 32'd1);
    check("stray_resp_b", {31'd0, resp_b}, 32'd0);

    // Timeout on the TIMEOUT_CYCLES=4 instance
    req_cnt = 0; resp_at = 0; cause_cap = 2'b00; fault_cap = 1'b0;
    issue(1'b0, 1'b1, 3'b010, 32'h0000_4000, 32'd0);
    cycle();
    for (int i = 1; i <= 8; i++) begin
      if (req_b) req_cnt++;
      if (resp_b && resp_at == 0) begin
        resp_at   = i;
        cause_cap = cause_b;
        fault_cap = fault_b;
      end
      cycle();
    end
    check("to_req_cycles", req_cnt, 32'd4);
    check("to_resp_cycle", resp_at, 32'd5);
    check("to_cause", {30'd0, cause_cap}, 32'd3);
    check("to_fault", {31'd0, fault_cap}, 32'd1);

    // Reset in REQ (instance a still waiting with default timeout)
    check("rstreq_pre", {31'd0, req_a}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstreq_req",   {31'd0, req_a},   32'd0);
    check("rstreq_ready", {31'd0, ready_a}, 32'd1);
    check("rstreq_resp",  {31'd0, resp_a},  32'd0);
    dmem_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    check("late_ack_resp",  {31'd0, resp_a},  32'd0);
    check("late_ack_req",   {31'd0, req_a},   32'd0);
    check("late_ack_ready", {31'd0, ready_a}, 32'd1);

    // Normal access after reset
    issue(1'b1, 1'b0, 3'b010, 32'h0000_5008, 32'h1234_5678);
    cycle();
    check("post_req",  {31'd0, req_a}, 32'd1);
    check("post_addr", daddr_a,        32'h0000_5008);
    dmem_ack = 1'b1;
    cycle();
    check("post_resp",  {31'd0, resp_a},  32'd1);
    check("post_fault", {31'd0, fault_a}, 32'd0);
    cycle();
    check("post_idle", {31'd0, resp_a}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage downstream of the instruction decoder. It takes decoded load/store requests (LB/LH/LW/LBU/LHU, SB/SH/SW) with the ALU-computed address, and runs one word-aligned transaction on the data-memory bus using a req/ack handshake. Load data is returned sign- or zero-extended to the register write-back mux (source 2'b10). The block stalls the core while a transaction is outstanding, and flags misaligned, illegal and timed-out accesses.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles in REQ without `dmem_ack_i` before the access is aborted. Range 1..255.

- `clk_i`  in  1  clock; all state on rising edge
- `rst_n_i`  in  1  asynchronous, active-low reset
- `req_valid_i`  in  1  decoded access present
- `req_ready_o`  out  1  unit can accept; high iff state IDLE
- `mem_write_enable_i`  in  1  store (from decoder)
- `mem_read_enable_i`  in  1  load (decoder `reg_write_src_o == 2'b10`)
- `funct3_i`  in  3  access size/sign
- `addr_i`  in  32  byte address from ALU
- `store_data_i`  in  32  rs2 value
- `resp_valid_o`  out  1  one-cycle completion pulse
- `load_data_o`  out  32  extended load result; valid with `resp_valid_o`
- `fault_o`  out  1  completion is a fault; valid with `resp_valid_o`
- `fault_cause_o`  out  2  01 misaligned, 10 illegal funct3, 11 bus timeout
- `stall_o`  out  1  hold fetch/decode
- `dmem_req_o`  out  1  bus request
- `dmem_we_o`  out  1  bus write
- `dmem_addr_o`  out  32  word address, `{addr_i[31:2],2'b00}`
- `dmem_be_o`  out  4  byte enables
- `dmem_wdata_o`  out  32  lane-replicated store data
- `dmem_rdata_i`  in  32  read data; valid with ack
- `dmem_ack_i`  in  1  transfer complete

## Operation
- FSM states: IDLE, REQ, RESP.
- Accept condition: IDLE && `req_valid_i` && (`mem_write_enable_i` || `mem_read_enable_i`). If both enables are set, the access is a store. Requests with neither enable are ignored.
- Legal loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000, 001, 010. Anything else → cause 10.
- Misaligned: half-word access with `addr[0]=1`, or word access with `addr[1:0]!=0` → cause 01. Illegal funct3 takes priority over misaligned.
- Fault at accept: IDLE→RESP with no bus activity.
- Good access at accept: IDLE→REQ. Register addr, we, be and wdata. Clear the timeout counter.
- Store lanes:
  - SB: `be = 1<<addr[1:0]`, `wdata = {4{b}}`
  - SH: `be = addr[1] ? 1100 : 0011`, `wdata = {2{h}}`
  - SW: `be = 1111`
- Loads drive `be` the same way as stores of the same size. `dmem_wdata_o` is 0 for loads.
- In REQ:
  - `dmem_req_o` and all bus outputs are held stable.
  - On `dmem_ack_i=1`: register the extracted load data, go to RESP.
  - Otherwise the counter increments. When it reaches `TIMEOUT_CYCLES`, drop the request, set cause 11, go to RESP.
- Load extract: select the byte at `addr[1:0]` or the half at `addr[1]`. Sign-extend for LB/LH, zero-extend for LBU/LHU; LW passes the word through. Stores return `load_data_o=0`.
- RESP: `resp_valid_o=1` for exactly one cycle, then IDLE.
- `dmem_ack_i` outside REQ is ignored.

## Timing
- Reset values: `dmem_req_o`, `dmem_we_o`, `resp_valid_o`, `fault_o`, `stall_o` = 0; `dmem_addr_o`, `dmem_be_o`, `dmem_wdata_o`, `load_data_o`, `fault_cause_o` = 0. State is IDLE, so `req_ready_o` reads 1.
- Bus access accepted in cycle N:
  - `dmem_req_o` is high from N+1.
  - If ack arrives in cycle N+k, `resp_valid_o` is high in N+k+1 and `dmem_req_o` is low from N+k+1.
  - Minimum latency is accept→resp = 2 cycles.
- Fault at accept: `resp_valid_o` in N+1, no bus request.
- Timeout: the request drops after `TIMEOUT_CYCLES` REQ cycles; `resp_valid_o` follows in the next cycle.
- `stall_o` is combinational. It is high in the accept cycle, and through every REQ cycle. It is low in RESP, so the core advances alongside `resp_valid_o`.
- No backpressure on the response. Next accept is possible in the cycle after RESP.
- Reset asserted mid-transaction: state returns to IDLE at once and `dmem_req_o` falls asynchronously. No `resp_valid_o` is produced; a late ack after reset is ignored.

## Test plan
- SW, addr 0x0000_1004, data 0xDEADBEEF, ack on the first REQ cycle → `dmem_addr_o=0x1004`, `be=1111`, `wdata=0xDEADBEEF`, `resp_valid_o` 2 cycles after accept, `fault_o=0`.
- LB at 0x1003 with rdata 0x80xx_xxxx → `load_data_o=0xFFFFFF80`. LBU at the same address → `0x00000080`. LHU at 0x1002 with rdata 0xBEEF_1234 → `0x0000BEEF`.
- SH at 0x2002, data 0x0000_ABCD → `be=1100`, `wdata=0xABCDABCD`. Ack delayed 5 cycles → `stall_o` high for 6 cycles, `resp_valid_o` on cycle 7 after accept.
- LW at 0x3001 → no `dmem_req_o`, `resp_valid_o` on the next cycle with `fault_o=1`, cause 01. Load with funct3=011 → cause 10.
- `TIMEOUT_CYCLES=4`, no ack → `dmem_req_o` high for 4 cycles, then `resp_valid_o` with cause 11. A stray `dmem_ack_i` in IDLE has no effect.
- `rst_n_i` pulsed low during REQ → `dmem_req_o` low immediately, no response, `req_ready_o=1`; a new access is accepted normally after reset is released.
